serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle WIDTH-bit subtractor. Computes Diff = IN1 - IN2 - Bin, one bit per clock, LSB first.
- Built as the subtract-direction counterpart of the ripple adder datapath. The borrow chain is held in one flip-flop instead of a combinational ripple chain.
- Used in area-constrained arithmetic paths. Accepts operands through a valid/ready start handshake and returns the result through a valid/ready done handshake.

Parameters:
- WIDTH, 4: operand and result width in bits; legal range 2..32.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- IN1  input  WIDTH  minuend; sampled on start handshake.
- IN2  input  WIDTH  subtrahend; sampled on start handshake.
- Bin  input  1  borrow-in; sampled on start handshake.
- start_valid  input  1  operands valid.
- start_ready  output  1  block idle, can accept operands.
- Diff  output  WIDTH  difference result.
- Borrow  output  1  borrow-out from MSB (1 = IN1 < IN2 + Bin, unsigned).
- done_valid  output  1  Diff/Borrow valid.
- done_ready  input  1  consumer accepts result.

Behaviour:
- Reset: while RST_N=0, all registers clear asynchronously.
  - State=IDLE; Diff=0, Borrow=0, done_valid=0; start_ready=1 (decoded from IDLE); bit counter=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: load IN1 and IN2 into shift registers A and B, borrow flop <= Bin, counter <= 0, go to SHIFT.
- SHIFT:
  - start_ready=0, done_valid=0.
  - Each cycle, with a=A[0], b=B[0], br=borrow flop:
    - d = a ^ b ^ br
    - br' = (~a & b) | (~(a ^ b) & br)
  - Shift d into the result register from the MSB end; shift A and B right; borrow flop <= br'; counter++.
  - When counter reaches WIDTH-1, the final bit is processed that cycle: Diff <= full result, Borrow <= br', go to DONE.
- DONE:
  - done_valid=1; Diff and Borrow held stable until done_ready=1.
  - On done_valid & done_ready: go to IDLE. Diff and Borrow keep their values; only done_valid drops.
- Latency: start handshake at edge k gives done_valid=1 after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum.
- No overlap: start_ready=0 in SHIFT and DONE. start_valid arriving in DONE, even in the same cycle as done_ready, is accepted only in the following IDLE cycle.
- Arithmetic is modulo 2^WIDTH; Borrow is the unsigned underflow indicator.
- done_ready is ignored outside DONE. start_valid is ignored outside IDLE.
- Input operands are don't-care except at the start handshake.
- Reset mid-operation aborts the operation immediately; no partial result is presented.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port Ovf (1 bit), registered with Diff and reset to 0.
  - Ovf = signed two's-complement overflow = (IN1[MSB] ^ IN2[MSB]) & (IN1[MSB] ^ Diff[MSB]).
  - Operand MSBs are captured at start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum typedef (IDLE, SHIFT, DONE);
  - default WIDTH constant;
  - counter-width function $clog2(WIDTH).
- One natural sub-module: full_subtractor, a 1-bit combinational unit (a, b, bin -> d, bout) instantiated once in the serial datapath.

Test Plan:
- WIDTH=4, IN1=9, IN2=3, Bin=0 -> Diff=6, Borrow=0; done_valid rises exactly 4 cycles after the start handshake edge.
- IN1=3, IN2=9, Bin=0 -> Diff=0xA, Borrow=1. Then IN1=5, IN2=5, Bin=1 -> Diff=0xF, Borrow=1.
- Result 0xC-0x4 with done_ready held 0 for 3 cycles -> Diff=0x8 and done_valid stable, start_ready=0 throughout.
  - Assert done_ready with start_valid=1 -> next op accepted the cycle after return to IDLE.
- Assert RST_N=0 two cycles into SHIFT -> immediately done_valid=0, Diff=0, Borrow=0, start_ready=1.
  - After release, 0xF-0x1 -> Diff=0xE, Borrow=0.
- Exhaustive sweep of all 4-bit IN1/IN2/Bin with random done_ready back-pressure -> every result matches the reference model (IN1-IN2-Bin) mod 16, with correct Borrow.
- With SERIAL_SUBTRACTOR_OVF_EN: 0x8-0x1 -> Diff=0x7, Ovf=1; 0x7-0x1 -> Diff=0x6, Ovf=0; 0x7-0xF -> Diff=0x8, Ovf=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; WIDTH is at least 2, so this is never zero.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready start and done handshakes.
// Optional signed overflow output Ovf is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             Bin,
    input  logic             start_valid,
    output logic             start_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             done_valid,
    input  logic             done_ready
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             msb1;
    logic             msb2;
`endif

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    assign start_ready = (state == IDLE);

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            Diff       <= '0;
            Borrow     <= 1'b0;
            done_valid <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            msb1       <= 1'b0;
            msb2       <= 1'b0;
            Ovf        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr  <= IN1;
                        b_sr  <= IN2;
                        br    <= Bin;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        msb1  <= IN1[WIDTH-1];
                        msb2  <= IN2[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= {d, a_sr[WIDTH-1:1]};
                    b_sr <= b_sr >> 1;
                    br   <= bout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Diff       <= {d, a_sr[WIDTH-1:1]};
                        Borrow     <= bout;
                        done_valid <= 1'b1;
                        state      <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        Ovf        <= (msb1 ^ msb2) & (msb1 ^ d);
`endif
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases, reset abort, back-pressure and full 4-bit sweep.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             bin = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             done_valid;
    logic             done_ready = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   rdy_random = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .IN1         (in1),
        .IN2         (in2),
        .Bin         (bin),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .Diff        (diff),
        .Borrow      (borrow),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .Ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: plain integer subtraction, wrapped to WIDTH bits.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic b);
        exp_t e;
        int   r;
        r        = int'(x) - int'(y) - int'(b);
        e.diff   = WIDTH'(r);
        e.borrow = (r < 0);
        e.ovf    = (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ e.diff[WIDTH-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Present operands until accepted; call shortly after a rising edge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic b);
        int n;
        in1 = x;
        in2 = y;
        bin = b;
        start_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("start_accept_timeout", 32'(start_ready), 32'd1);
        q.push_back(model(x, y, b));
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) done_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency on each rising done_valid, result on each done handshake.
    initial begin
        bit   prev_dv;
        exp_t e;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_dv = 1'b0;
            end else begin
                if (done_valid && !prev_dv)
                    check("latency", 32'(cyc - start_cyc), 32'(WIDTH));
                if (done_valid && done_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_result: got diff %0h with no operation pending", diff);
                    end else begin
                        e = q.pop_front();
                        check("diff", 32'(diff), 32'(e.diff));
                        check("borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                    end
                end
                prev_dv = done_valid;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'h9, 4'h3, 1'b0);
        issue(4'h3, 4'h9, 1'b0);
        issue(4'h5, 4'h5, 1'b1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        issue(4'h8, 4'h1, 1'b0);
        issue(4'h7, 4'h1, 1'b0);
        issue(4'h7, 4'hF, 1'b0);
`endif

        // Back-pressure: result must hold while done_ready stays low.
        issue(4'hC, 4'h4, 1'b0);
        done_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_done_valid", 32'(done_valid), 32'd1);
            check("hold_diff", 32'(diff), 32'h8);
            check("hold_start_ready", 32'(start_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        done_ready  = 1'b1;
        start_valid = 1'b1;
        in1 = 4'h6;
        in2 = 4'h2;
        bin = 1'b0;
        @(negedge clk);
        check("done_hs_start_ready", 32'(start_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_start_ready", 32'(start_ready), 32'd1);
        check("idle_done_valid", 32'(done_valid), 32'd0);
        check("idle_diff_kept", 32'(diff), 32'h8);
        q.push_back(model(4'h6, 4'h2, 1'b0));
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        check("accepted_start_ready", 32'(start_ready), 32'd0);

        // Reset two cycles into SHIFT aborts the operation.
        n = 0;
        while (!start_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        issue(4'hA, 4'h3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_done_valid", 32'(done_valid), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(4'hF, 4'h1, 1'b0);

        // Exhaustive sweep under random back-pressure.
        rdy_random = 1'b1;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int b = 0; b < 2; b++)
                    issue(4'(x), 4'(y), 1'(b));

        n = 0;
        while ((q.size() != 0 || done_valid) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("drain_pending", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
